// File: rtl/intr_pkg.sv
// Shared types and constants for the machine-mode interrupt controller.
package intr_pkg;

  // Trap handshake phase: waiting for a source, requesting, handler running.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intr_state_e;

  // mcause values for the two interrupt sources (interrupt bit set).
  localparam logic [31:0] CAUSE_EXT = 32'h8000000B;
  localparam logic [31:0] CAUSE_TMR = 32'h80000007;

  // Bit positions of the enables in mie and the pending flags in mip.
  localparam int MEIE = 11;
  localparam int MTIE = 7;

endpackage

// File: rtl/intr_ctrl_if.sv
// Trap handshake between the interrupt controller and the pipeline.
//
// Handshake: the controller raises intr_req with intr_cause and holds both
// stable until either the pipeline answers with a one-cycle trap_ack (the
// trap is taken and in_service rises the next cycle) or the selected source
// loses eligibility (intr_req drops the next cycle). An ack in the same cycle
// as a loss of eligibility counts as the ack. While in_service is high the
// pipeline ends the handler with a one-cycle mret pulse. trap_ack while
// intr_req is low and mret while in_service is low have no effect.
interface intr_ctrl_if;
  import intr_pkg::*;

  logic        intr_req;
  logic [31:0] intr_cause;
  logic        in_service;
  logic        trap_ack;
  logic        mret;
  intr_state_e state;   // controller phase, exposed for debug and checkers

  modport master (
    output intr_req,
    output intr_cause,
    output in_service,
    output state,
    input  trap_ack,
    input  mret
  );

  modport slave (
    input  intr_req,
    input  intr_cause,
    input  in_service,
    input  state,
    output trap_ack,
    output mret
  );

endinterface

// File: rtl/intr_timer.sv
// Machine timer: free-running mtime, writable mtimecmp, registered mtip flag.
module intr_timer #(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmp_we,
  input  logic [TIMER_W-1:0] cmp_wdata,
  output logic [TIMER_W-1:0] mtime,
  output logic               mtip
);

  logic [TIMER_W-1:0] mtime_q, mtime_d;
  logic [TIMER_W-1:0] mtimecmp_q, mtimecmp_d;
  logic               mtip_q, mtip_d;

  // Next-state: count every cycle (wrapping), load compare on write, and
  // compare against the compare value that is already registered, so a new
  // compare value is seen one cycle after it lands.
  always_comb begin
    mtime_d    = mtime_q + TIMER_W'(1);
    mtimecmp_d = mtimecmp_q;
    if (cmp_we) begin
      mtimecmp_d = cmp_wdata;
    end
    mtip_d = (mtime_q >= mtimecmp_q);
  end

  // Timer registers; compare starts at all-ones so nothing fires out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      mtip_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      mtip_q     <= mtip_d;
    end
  end

  assign mtime = mtime_q;
  assign mtip  = mtip_q;

endmodule

// File: rtl/intr_ctrl.sv
// Machine-mode interrupt controller: external pending latch, machine timer,
// fixed-priority arbitration and the trap entry/return sequencer.
module intr_ctrl #(
  parameter int          TIMER_W   = 32,
  parameter logic [31:0] CAUSE_EXT = intr_pkg::CAUSE_EXT,
  parameter logic [31:0] CAUSE_TMR = intr_pkg::CAUSE_TMR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ext_intr,
  input  logic               csr_mstatus_mie,
  input  logic               csr_meie,
  input  logic               csr_mtie,
  input  logic               cmp_we,
  input  logic [TIMER_W-1:0] cmp_wdata,
  intr_ctrl_if.master        bus,
  output logic               mip_meip,
  output logic               mip_mtip,
  output logic [TIMER_W-1:0] mtime
);
  import intr_pkg::*;

  intr_state_e state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic        ext_q;
  logic        meip_q, meip_d;
  logic        mtip;
  logic        ext_ok, tmr_ok, sel_ok, ack_acc, ext_edge, ext_clr;

  intr_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .cmp_we    (cmp_we),
    .cmp_wdata (cmp_wdata),
    .mtime     (mtime),
    .mtip      (mtip)
  );

  // Eligibility of each source and the external pending-bit update; a fresh
  // edge beats the clear from an accepted external trap in the same cycle.
  always_comb begin
    ext_ok   = meip_q & csr_meie & csr_mstatus_mie;
    tmr_ok   = mtip & csr_mtie & csr_mstatus_mie;
    sel_ok   = (cause_q == CAUSE_EXT) ? ext_ok : tmr_ok;
    ack_acc  = bus.trap_ack & (state_q == REQ);
    ext_edge = ext_intr & ~ext_q;
    ext_clr  = ack_acc & (cause_q == CAUSE_EXT);
    meip_d   = ext_edge | (meip_q & ~ext_clr);
  end

  // Trap sequencer: arbitrate only in IDLE so the cause is frozen while the
  // pipeline is asked, and never raise a request during a handler.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (ext_ok) begin
          state_d = REQ;
          cause_d = CAUSE_EXT;
        end else if (tmr_ok) begin
          state_d = REQ;
          cause_d = CAUSE_TMR;
        end
      end
      REQ: begin
        if (ack_acc) begin
          state_d = SERVICE;
        end else if (!sel_ok) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (bus.mret) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer, cause and external-interrupt registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cause_q <= '0;
      ext_q   <= 1'b0;
      meip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      ext_q   <= ext_intr;
      meip_q  <= meip_d;
    end
  end

  // Handshake outputs decode straight from the phase so reset drops them at once.
  assign bus.intr_req   = (state_q == REQ);
  assign bus.in_service = (state_q == SERVICE);
  assign bus.intr_cause = cause_q;
  assign bus.state      = state_q;
  assign mip_meip       = meip_q;
  assign mip_mtip       = mtip;

  // A request and a running handler never overlap.
  a_req_svc_excl: assert property (@(posedge clk) disable iff (reset)
    !((state_q == REQ) && (state_q == SERVICE) ) && !(bus.intr_req && bus.in_service));

  // The cause stays put for as long as the request is held.
  a_cause_stable: assert property (@(posedge clk) disable iff (reset)
    ((state_q == REQ) && (state_d == REQ)) |=> $stable(cause_q));

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_intr_ctrl;
  import intr_pkg::*;

  localparam int          TW    = 32;
  localparam logic [31:0] C_EXT = 32'h8000000B;
  localparam logic [31:0] C_TMR = 32'h80000007;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ext_intr = 1'b0;
  logic          csr_mstatus_mie = 1'b0;
  logic          csr_meie = 1'b0;
  logic          csr_mtie = 1'b0;
  logic          cmp_we = 1'b0;
  logic [TW-1:0] cmp_wdata = '0;
  logic          mip_meip, mip_mtip;
  logic [TW-1:0] mtime;

  always #5 clk = ~clk;

  intr_ctrl_if bus();

  intr_ctrl #(.TIMER_W(TW)) dut (
    .clk             (clk),
    .reset           (reset),
    .ext_intr        (ext_intr),
    .csr_mstatus_mie (csr_mstatus_mie),
    .csr_meie        (csr_meie),
    .csr_mtie        (csr_mtie),
    .cmp_we          (cmp_we),
    .cmp_wdata       (cmp_wdata),
    .bus             (bus),
    .mip_meip        (mip_meip),
    .mip_mtip        (mip_mtip),
    .mtime           (mtime)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = no request, 1 = requesting, 2 = handler running
  logic [TW-1:0] m_time = '0;
  logic [TW-1:0] m_cmp = '1;
  bit            m_mtip = 0, m_meip = 0, m_ext_prev = 0;
  int            m_phase = 0;
  logic [31:0]   m_cause = '0;
  logic [31:0]   exp_q[$];   // causes of requests the model predicts, in order

  task automatic model_step();
    bit e_ok, t_ok, acked, sel_ok;
    e_ok   = m_meip && csr_meie && csr_mstatus_mie;
    t_ok   = m_mtip && csr_mtie && csr_mstatus_mie;
    acked  = (m_phase == 1) && bus.trap_ack;
    sel_ok = (m_cause == C_EXT) ? e_ok : t_ok;
    if (m_phase == 0) begin
      if (e_ok || t_ok) begin
        m_phase = 1;
        m_cause = e_ok ? C_EXT : C_TMR;
        exp_q.push_back(m_cause);
      end
    end else if (m_phase == 1) begin
      if (acked) m_phase = 2;
      else if (!sel_ok) m_phase = 0;
    end else if (bus.mret) begin
      m_phase = 0;
    end
    m_meip     = (ext_intr && !m_ext_prev) || (m_meip && !(acked && m_cause == C_EXT));
    m_ext_prev = ext_intr;
    m_mtip     = (m_time >= m_cmp);
    if (cmp_we) m_cmp = cmp_wdata;
    m_time     = m_time + 1;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_time = '0; m_cmp = '1; m_mtip = 0; m_meip = 0; m_ext_prev = 0;
      m_phase = 0; m_cause = '0;
      exp_q.delete();
    end else begin
      model_step();
    end
  end

  // ---------------- per-cycle compare / scoreboard ----------------
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      chk("intr_req",   32'(bus.intr_req),   32'(m_phase == 1));
      chk("in_service", 32'(bus.in_service), 32'(m_phase == 2));
      chk("mip_meip",   32'(mip_meip),       32'(m_meip));
      chk("mip_mtip",   32'(mip_mtip),       32'(m_mtip));
      chk("mtime",      mtime,               m_time);
      chk("state", 32'(bus.state),
          32'((m_phase == 1) ? REQ : (m_phase == 2) ? SERVICE : IDLE));
      if (bus.intr_req) chk("intr_cause", bus.intr_cause, m_cause);
      if (bus.intr_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_raise: got request %0h expected none at %0t", bus.intr_cause, $time);
        end else begin
          chk("sb_cause", bus.intr_cause, exp_q.pop_front());
        end
      end
      prev_req = bus.intr_req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ext_intr = 0; csr_mstatus_mie = 0; csr_meie = 0; csr_mtie = 0;
    cmp_we = 0; cmp_wdata = '0; bus.trap_ack = 0; bus.mret = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic wait_time(input logic [TW-1:0] t);
    for (int i = 0; i < 200; i++) begin
      if (m_time == t) return;
      step();
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_time: got mtime %0d expected %0d within budget", m_time, t);
  endtask

  task automatic pulse_ack();
    bus.trap_ack = 1; step(); bus.trap_ack = 0;
  endtask

  task automatic pulse_mret();
    bus.mret = 1; step(); bus.mret = 0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    bus.trap_ack = 0;
    bus.mret = 0;
    do_reset();

    // Reset state
    chk("rst_req", 32'(bus.intr_req), 0);
    chk("rst_svc", 32'(bus.in_service), 0);
    chk("rst_meip", 32'(mip_meip), 0);
    chk("rst_mtip", 32'(mip_mtip), 0);
    chk("rst_cause", bus.intr_cause, 0);

    // Basic external trap
    csr_mstatus_mie = 1; csr_meie = 1; csr_mtie = 1;
    ext_intr = 1; step(); ext_intr = 0;
    chk("ext_meip_set", 32'(mip_meip), 1);
    chk("ext_req_lat", 32'(bus.intr_req), 0);
    step();
    chk("ext_req", 32'(bus.intr_req), 1);
    chk("ext_cause", bus.intr_cause, 32'h8000000B);
    pulse_ack();
    chk("ext_ack_req", 32'(bus.intr_req), 0);
    chk("ext_ack_svc", 32'(bus.in_service), 1);
    chk("ext_ack_meip", 32'(mip_meip), 0);
    pulse_mret();
    chk("ext_mret_svc", 32'(bus.in_service), 0);

    // Timer trap
    do_reset();
    csr_mstatus_mie = 1; csr_mtie = 1;
    wait_time(10);
    cmp_we = 1; cmp_wdata = 20; step(); cmp_we = 0;
    wait_time(20);
    chk("tmr_mtip_pre", 32'(mip_mtip), 0);
    step();
    chk("tmr_mtip_set", 32'(mip_mtip), 1);
    chk("tmr_mtime", mtime, 21);
    step();
    chk("tmr_req", 32'(bus.intr_req), 1);
    chk("tmr_cause", bus.intr_cause, 32'h80000007);
    pulse_ack();
    chk("tmr_svc", 32'(bus.in_service), 1);
    cmp_we = 1; cmp_wdata = '1; step(); cmp_we = 0;
    step();
    chk("tmr_mtip_clr", 32'(mip_mtip), 0);
    pulse_mret();
    step();
    chk("tmr_no_rereq", 32'(bus.intr_req), 0);

    // Priority: external wins over an already pending timer
    do_reset();
    csr_meie = 1; csr_mtie = 1;
    cmp_we = 1; cmp_wdata = 5; step(); cmp_we = 0;
    for (int i = 0; i < 20; i++) begin
      if (mip_mtip) break;
      step();
    end
    chk("pri_mtip", 32'(mip_mtip), 1);
    ext_intr = 1; step(); ext_intr = 0;
    chk("pri_masked", 32'(bus.intr_req), 0);
    csr_mstatus_mie = 1; step();
    chk("pri_first", bus.intr_cause, 32'h8000000B);
    pulse_ack();
    pulse_mret();
    chk("pri_gap", 32'(bus.intr_req), 0);
    step();
    chk("pri_second_req", 32'(bus.intr_req), 1);
    chk("pri_second", bus.intr_cause, 32'h80000007);
    pulse_ack();
    csr_mtie = 0;
    pulse_mret();

    // Withdrawal, then ack racing a new edge, then a held-high input
    do_reset();
    csr_mstatus_mie = 1; csr_meie = 1;
    ext_intr = 1; step(); ext_intr = 0; step();
    chk("wd_req", 32'(bus.intr_req), 1);
    csr_meie = 0; step();
    chk("wd_dropped", 32'(bus.intr_req), 0);
    chk("wd_state", 32'(bus.state), 32'(IDLE));
    chk("wd_meip", 32'(mip_meip), 1);
    csr_meie = 1; step();
    chk("wd_reraise", 32'(bus.intr_req), 1);
    bus.trap_ack = 1; ext_intr = 1; step(); bus.trap_ack = 0;
    chk("race_meip", 32'(mip_meip), 1);
    chk("race_svc", 32'(bus.in_service), 1);
    pulse_mret();
    step();
    chk("hold_req", 32'(bus.intr_req), 1);
    pulse_ack();
    chk("hold_meip_clr", 32'(mip_meip), 0);
    step();
    ext_intr = 0;
    chk("hold_one_set", 32'(mip_meip), 0);
    pulse_mret();

    // Reset while requesting
    ext_intr = 1; step(); ext_intr = 0; step();
    chk("rreq_req", 32'(bus.intr_req), 1);
    reset = 1;
    #1;
    chk("rreq_req0", 32'(bus.intr_req), 0);
    chk("rreq_svc0", 32'(bus.in_service), 0);
    chk("rreq_meip0", 32'(mip_meip), 0);
    chk("rreq_mtime0", mtime, 0);
    chk("rreq_cause0", bus.intr_cause, 0);
    step();
    reset = 0;

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) ext_intr = ~ext_intr;
      csr_mstatus_mie = ($urandom_range(0, 15) != 0);
      csr_meie        = ($urandom_range(0, 11) != 0);
      csr_mtie        = ($urandom_range(0, 11) != 0);
      cmp_we          = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0:       cmp_wdata = '1;
        1:       cmp_wdata = m_time - TW'($urandom_range(0, 10));
        default: cmp_wdata = m_time + TW'($urandom_range(0, 40));
      endcase
      bus.trap_ack = ($urandom_range(0, 3) == 0);
      bus.mret     = ($urandom_range(0, 5) == 0);
      step();
    end
    idle_inputs();
    step();
    step();
    chk("sb_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
Machine-mode interrupt controller for the RV32I pipeline with CSR. It latches the external interrupt pulse and runs a free-running machine timer with a compare register. It arbitrates between external and timer sources and gates them with the mstatus.MIE and mie enables. It then sequences trap entry and return with the pipeline through a request/acknowledge handshake and the mret strobe.

Parameters:
TIMER_W, 32, width of the mtime counter and the mtimecmp register
CAUSE_EXT, 32'h8000000B, mcause value for a machine external interrupt
CAUSE_TMR, 32'h80000007, mcause value for a machine timer interrupt

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
ext_intr  input  1  external interrupt; a rising edge is latched as pending
csr_mstatus_mie  input  1  global machine interrupt enable
csr_meie  input  1  mie[11], external interrupt enable
csr_mtie  input  1  mie[7], timer interrupt enable
cmp_we  input  1  write strobe for mtimecmp
cmp_wdata  input  TIMER_W  new mtimecmp value
trap_ack  input  1  one-cycle pulse: pipeline has flushed, written mepc and mcause, and redirected to mtvec
mret  input  1  one-cycle pulse: pipeline has retired mret
intr_req  output  1  interrupt request to the pipeline
intr_cause  output  32  mcause value; valid while intr_req is high
mip_meip  output  1  mip[11], external pending
mip_mtip  output  1  mip[7], timer pending
in_service  output  1  high while a trap handler is executing
mtime  output  TIMER_W  current timer value

Behaviour:
- Reset values: all outputs 0. mtimecmp resets to all-ones. State resets to IDLE. The ext_intr edge-detect register resets to 0.
- mtime increments by 1 every cycle and wraps from all-ones to 0.
- mip_mtip is a registered flag equal to (mtime >= mtimecmp), using an unsigned compare. A cmp_we write takes effect next cycle, and mip_mtip re-evaluates against the new value the cycle after that.
- meip set/clear:
  - Set on the rising edge of ext_intr, i.e. ext_intr & ~ext_intr_q.
  - Cleared in the cycle trap_ack is accepted with intr_cause == CAUSE_EXT.
  - If a new edge and that clear occur in the same cycle, set wins.
- Eligibility:
  - ext_ok = meip & csr_meie & csr_mstatus_mie.
  - tmr_ok = mtip & csr_mtie & csr_mstatus_mie.
  - Fixed priority: external over timer.
- FSM IDLE:
  - If ext_ok or tmr_ok, the next cycle asserts intr_req with the winning cause registered, and the state moves to REQ.
  - Latency from pending-bit set to intr_req is 1 cycle.
- FSM REQ:
  - intr_req and intr_cause are held stable; the cause is not re-arbitrated while waiting.
  - On trap_ack: next state is SERVICE, intr_req drops, and in_service rises.
  - If the selected source becomes ineligible before the ack (enable cleared, or mtip cleared by a cmp write): intr_req is withdrawn the next cycle and the state returns to IDLE.
  - An ack and a withdrawal in the same cycle resolve as the ack.
- FSM SERVICE:
  - No new request is raised, so there is no nesting.
  - On mret: next state is IDLE and in_service drops. Re-arbitration can raise intr_req one cycle after that.
- trap_ack outside REQ and mret outside SERVICE are ignored.
- Asserting reset mid-handshake immediately drops intr_req and in_service, and discards pending meip.

Decomposition:
- Package intr_pkg holds:
  - the state enum (IDLE, REQ, SERVICE);
  - the CAUSE_EXT and CAUSE_TMR constants;
  - the mie bit indices (MEIE = 11, MTIE = 7).
- One natural sub-module, intr_timer: the mtime counter, the mtimecmp register and the mtip compare.
- Arbitration and the FSM stay in intr_ctrl.

Test Plan:
- Basic external trap:
  - Setup: enables 1; pulse ext_intr for 1 cycle.
  - Expect: next cycle mip_meip = 1; one cycle later intr_req = 1 with intr_cause = 32'h8000000B.
  - trap_ack: intr_req drops, in_service = 1, meip = 0.
  - mret: in_service = 0.
- Timer trap:
  - Setup: write cmp = 20 at mtime = 10.
  - Expect: mip_mtip rises when mtime reaches 20; intr_req follows with intr_cause = 32'h80000007.
  - A cmp write of all-ones during SERVICE clears mtip.
- Priority:
  - Setup: mtip already pending while mstatus_mie = 0; pulse ext_intr; then set mstatus_mie = 1.
  - Expect: first request carries CAUSE_EXT.
  - After ack and mret, the second request carries CAUSE_TMR.
- Withdrawal:
  - Setup: in REQ for an external interrupt, clear csr_meie before trap_ack.
  - Expect: intr_req = 0 the next cycle, state IDLE, meip stays 1.
  - Re-setting meie re-raises the request.
- Edge cases:
  - A new ext_intr edge in the same cycle as trap_ack leaves meip = 1.
  - Holding ext_intr high for 5 cycles produces only one pending set.
  - Asserting reset while in REQ drops intr_req asynchronously, with all outputs 0.
